// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: instruction field positions, opcodes used by
// operand fetch, and the decoded-field bundle carried to execute.
package mips_pkg;

  localparam int INSTR_W  = 32;
  localparam int SEL_W    = 5;
  localparam int OPC_W    = 6;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;

  // Field bit positions
  localparam int OPC_LO   = 26;
  localparam int RS_LO    = 21;
  localparam int RT_LO    = 16;
  localparam int RD_LO    = 11;
  localparam int IMM_LO   = 0;
  localparam int FUNCT_LO = 0;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OPC_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;

  localparam logic [SEL_W-1:0] REG_ZERO = 5'd0;

  // Register-select and opcode fields split out of one instruction word
  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [SEL_W-1:0]   rs;
    logic [SEL_W-1:0]   rt;
    logic [SEL_W-1:0]   rd;
    logic [FUNCT_W-1:0] funct;
    logic [IMM_W-1:0]   imm;
  } instr_fields_t;

  function automatic instr_fields_t split_instr(input logic [INSTR_W-1:0] instr);
    instr_fields_t f;
    f.opcode = instr[OPC_LO   +: OPC_W];
    f.rs     = instr[RS_LO    +: SEL_W];
    f.rt     = instr[RT_LO    +: SEL_W];
    f.rd     = instr[RD_LO    +: SEL_W];
    f.funct  = instr[FUNCT_LO +: FUNCT_W];
    f.imm    = instr[IMM_LO   +: IMM_W];
    return f;
  endfunction

  // Register written by the instruction; REG_ZERO means "writes nothing"
  function automatic logic [SEL_W-1:0] dest_of(input instr_fields_t f);
    logic [SEL_W-1:0] d;
    case (f.opcode)
      OP_RTYPE: d = f.rd;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
      OP_ORI, OP_XORI, OP_LUI, OP_LW: d = f.rt;
      default:  d = REG_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_operand_fetch_scoreboard.sv
// Register busy scoreboard. One bit per architectural register, set when an
// instruction that writes it issues, cleared by writeback. Query ports report
// "busy and not being released this cycle" so stalls drop in the clearing cycle.
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int NREG = 32,
  parameter int NQ   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_en,
  input  logic [SEL_W-1:0]         set_sel,
  input  logic                     clr_en,
  input  logic [SEL_W-1:0]         clr_sel,
  input  logic [NQ-1:0][SEL_W-1:0] q_sel,
  output logic [NQ-1:0]            q_busy
);

  logic [NREG-1:0] busy_q, busy_d;

  // Next busy vector: clear first so a same-cycle set of the same bit wins
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_sel] = 1'b0;
    if (set_en) busy_d[set_sel] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  // Busy state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Query: a register being written back this cycle no longer blocks
  always_comb begin
    q_busy = '0;
    for (int i = 0; i < NQ; i++)
      q_busy[i] = busy_q[q_sel[i]] && !(clr_en && clr_sel == q_sel[i]);
  end

endmodule

// File: rtl/reg_operand_fetch.sv
// Decode / operand-read stage. Drives the register-file read selects straight
// from the offered instruction, bypasses a same-cycle writeback, stalls on
// busy sources/destination, and registers operands plus decoded fields for
// the execute stage behind a valid/ready handshake.
module reg_operand_fetch
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  output logic [4:0]         selA,
  output logic [4:0]         selB,
  input  logic [WIDTH-1:0]   ReadData1,
  input  logic [WIDTH-1:0]   ReadData2,
  input  logic               wb_en,
  input  logic [4:0]         wb_sel,
  input  logic [WIDTH-1:0]   wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_rs_val,
  output logic [WIDTH-1:0]   out_rt_val,
  output logic [WIDTH-1:0]   out_imm,
  output logic [5:0]         out_opcode,
  output logic [5:0]         out_funct,
  output logic [4:0]         out_dest
);

  instr_fields_t    f;
  logic [4:0]       dest;
  logic             wb_live;
  logic [WIDTH-1:0] rs_val, rt_val, imm_ext;
  logic [2:0]       q_busy;
  logic             hazard, accept;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_rs_val_q, out_rs_val_d;
  logic [WIDTH-1:0] out_rt_val_q, out_rt_val_d;
  logic [WIDTH-1:0] out_imm_q, out_imm_d;
  logic [5:0]       out_opcode_q, out_opcode_d;
  logic [5:0]       out_funct_q, out_funct_d;
  logic [4:0]       out_dest_q, out_dest_d;

  assign f       = split_instr(in_instr);
  assign dest    = dest_of(f);
  assign selA    = f.rs;
  assign selB    = f.rt;
  assign imm_ext = {{(WIDTH-IMM_W){f.imm[IMM_W-1]}}, f.imm};
  // A writeback to $zero has no architectural effect anywhere in this stage
  assign wb_live = wb_en && (wb_sel != REG_ZERO);

  // Operand select: $zero, then same-cycle writeback, then register file
  always_comb begin
    rs_val = ReadData1;
    rt_val = ReadData2;
    if (f.rs == REG_ZERO)                rs_val = '0;
    else if (wb_live && wb_sel == f.rs)  rs_val = wb_data;
    if (f.rt == REG_ZERO)                rt_val = '0;
    else if (wb_live && wb_sel == f.rt)  rt_val = wb_data;
  end

  reg_scoreboard #(.NREG(NREG), .NQ(3)) u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (accept && dest != REG_ZERO),
    .set_sel (dest),
    .clr_en  (wb_live),
    .clr_sel (wb_sel),
    .q_sel   ({dest, f.rt, f.rs}),
    .q_busy  (q_busy)
  );

  // RAW on rs/rt and WAW on dest all stall the same way
  always_comb begin
    hazard   = |q_busy;
    in_ready = (!out_valid_q || out_ready) && !hazard;
    accept   = in_valid && in_ready;
  end

  // Output register next state: load on accept, drop valid on bare consume
  always_comb begin
    out_valid_d  = out_valid_q;
    out_rs_val_d = out_rs_val_q;
    out_rt_val_d = out_rt_val_q;
    out_imm_d    = out_imm_q;
    out_opcode_d = out_opcode_q;
    out_funct_d  = out_funct_q;
    out_dest_d   = out_dest_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_rs_val_d = rs_val;
      out_rt_val_d = rt_val;
      out_imm_d    = imm_ext;
      out_opcode_d = f.opcode;
      out_funct_d  = f.funct;
      out_dest_d   = dest;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // Output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_rs_val_q <= '0;
      out_rt_val_q <= '0;
      out_imm_q    <= '0;
      out_opcode_q <= '0;
      out_funct_q  <= '0;
      out_dest_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_rs_val_q <= out_rs_val_d;
      out_rt_val_q <= out_rt_val_d;
      out_imm_q    <= out_imm_d;
      out_opcode_q <= out_opcode_d;
      out_funct_q  <= out_funct_d;
      out_dest_q   <= out_dest_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_rs_val = out_rs_val_q;
  assign out_rt_val = out_rt_val_q;
  assign out_imm    = out_imm_q;
  assign out_opcode = out_opcode_q;
  assign out_funct  = out_funct_q;
  assign out_dest   = out_dest_q;

endmodule

// File: doc/reg_operand_fetch.md
# reg_operand_fetch

Decode/operand-read stage for the MIPS datapath. Takes 32-bit instructions over a valid/ready handshake and drives the read ports of `banco_reg` (`selA`/`selB` in, `ReadData1`/`ReadData2` back). Returns registered operands, the decoded fields and the destination register to the execute stage. A 32-entry busy scoreboard, cleared by the writeback port, stalls RAW/WAW hazards. Same-cycle writeback values are bypassed around the register file.

## Interface
Parameters:
- `WIDTH`, 32, data word width
- `NREG`, 32, number of architectural registers (5-bit select)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  instruction offered
- `in_ready`  out  1  stage accepts instruction this cycle
- `in_instr`  in  32  instruction word, bit 31 = MSB
- `selA`  out  5  `banco_reg` read select 1; combinational `in_instr[25:21]` (rs)
- `selB`  out  5  `banco_reg` read select 2; combinational `in_instr[20:16]` (rt)
- `ReadData1`  in  WIDTH  register file data for `selA`, combinational
- `ReadData2`  in  WIDTH  register file data for `selB`, combinational
- `wb_en`  in  1  writeback this cycle; same signals drive the `banco_reg` write port
- `wb_sel`  in  5  writeback register
- `wb_data`  in  WIDTH  writeback value
- `out_valid`  out  1  decoded instruction held
- `out_ready`  in  1  execute stage consumes
- `out_rs_val`  out  WIDTH  rs operand
- `out_rt_val`  out  WIDTH  rt operand
- `out_imm`  out  WIDTH  sign-extended `instr[15:0]`
- `out_opcode`  out  6  `instr[31:26]`
- `out_funct`  out  6  `instr[5:0]`
- `out_dest`  out  5  destination register; 0 = none

## Operation
- **Destination decode:**
  - opcode 0x00 (R-type) → rd `instr[15:11]`.
  - opcodes 0x08, 0x09, 0x0A, 0x0C, 0x0D, 0x0E, 0x0F, 0x23 → rt.
  - All other opcodes → 0.
- **Operand select** (per source, rs and rt independently):
  - src == 0 → 0.
  - else `wb_en && wb_sel == src` → `wb_data`.
  - else ReadData.
- **Scoreboard:** `busy[31:0]`; bit 0 is hardwired 0.
  - `wb_en` clears `busy[wb_sel]`.
  - An accepted instruction sets `busy[dest]` when dest ≠ 0.
  - Set and clear of the same bit in the same cycle → set wins.
- **Hazard (combinational):** any of rs, rt, dest has busy = 1 and is not being cleared by `wb_en`/`wb_sel` this cycle.
- **`in_ready`** = `(!out_valid || out_ready) && !hazard`.
- **Accept** (`in_valid && in_ready`): the output register loads all fields and `out_valid` ← 1.
- **Consume without accept:** `out_valid` ← 0.
- **Holding:** output fields stay stable while `out_valid && !out_ready`.
- `wb_en` with `wb_sel` == 0 is ignored.

## Timing
- Latency: 1 cycle, accept edge → `out_valid`.
- Throughput: 1 instruction per cycle with no hazards and `out_ready` held at 1.
- Bypass covers only the writeback cycle itself. Later cycles read the updated `banco_reg` value.
- Stall release: same cycle as the clearing writeback (combinational clear check).
- **Reset (async):**
  - `out_valid` = 0; all `out_*` fields = 0; `busy` = 0.
  - `in_ready` = 1 once `reset` deasserts, because `out_valid` = 0 and nothing is busy.
  - Reset mid-stall drops the held instruction and all pending busy bits.
- Back-to-back: when `out_ready` = 1 the stage accepts while `out_valid` = 1. The register reloads with no bubble.

## Structure
- Shared package `mips_pkg`:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW
  - field bit positions
  - `REG_ZERO` = 0
- Sub-module `reg_scoreboard`: busy vector with set/clear ports and three busy-query ports.
- Top level holds decode, bypass mux and output register.

## Test plan
- **Reset, then isolated instruction:** `banco_reg` reg 18 = 70, reg 27 = 324; `in_instr` = 0x0252D820 (`add $27,$18,$18`; rs = rt = 18, rd = 27) → next cycle `out_rs_val` = `out_rt_val` = 70, `out_dest` = 27, `busy[27]` = 1.
- **RAW stall:** with `busy[27]` = 1, offer an instruction with rs = 27 → `in_ready` = 0. Assert `wb_en`, `wb_sel` = 27, `wb_data` = 140 → accepted that cycle; operand = 140 (bypass, not the stale 324).
- **$zero:** `addi $0,$0,5` → `out_rs_val` = 0, `out_dest` = 0, no busy bit set. `wb_en` to reg 0 with data 15 → rs = 0 still reads 0.
- **Backpressure:** `out_ready` = 0 for 3 cycles with `in_valid` held → outputs stable, `in_ready` = 0. `out_ready` = 1 → the next instruction loads with no bubble.
- **WAW plus same-cycle set/clear:** `busy[15]` = 1. `lw $15` is offered while `wb_sel` = 15 → accepted, and `busy[15]` stays 1.
- **Async reset mid-stall:** assert `reset` between clock edges → `out_valid` = 0 immediately and `busy` = 0. After deassert, `in_ready` = 1.
